// File: rtl/hamming_38_32_decoder.sv
// rtl/hamming_38_32_decoder.sv - [38,32] Hamming SEC decoder, 3-stage valid/ready pipeline with error counters.
// Optional DEC_ERR_INJECT_EN adds inj_en/inj_pos to flip one din bit before decode.
module hamming_38_32_decoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [37:0]      din,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [31:0]      dout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       syndrome,
    output logic             err_corr,
    output logic             err_uncorr,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
`ifdef DEC_ERR_INJECT_EN
    ,
    input  logic             inj_en,
    input  logic [5:0]       inj_pos
`endif
);

    localparam logic [31:0] M0 = 32'h56AAAD5B;
    localparam logic [31:0] M1 = 32'h9B33366D;
    localparam logic [31:0] M2 = 32'hE3C3C78E;
    localparam logic [31:0] M3 = 32'h03FC07F0;
    localparam logic [31:0] M4 = 32'h03FFF800;
    localparam logic [31:0] M5 = 32'hFC000000;

    // Codeword position (1..38) of data bit idx: the idx-th non-power-of-2 position.
    function automatic logic [5:0] data_pos(input int idx);
        int         n;
        logic [5:0] r;
        n = 0;
        r = '0;
        for (int p = 3; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) r = 6'(p);
                n++;
            end
        end
        return r;
    endfunction

    logic        adv;
    logic [37:0] word;
    logic [5:0]  chk;
    logic [5:0]  syn_in;

    logic        s1_valid;
    logic [31:0] s1_data;
    logic [5:0]  s1_syn;

    logic [31:0] flip;
    logic        corr_c;
    logic        uncorr_c;

    logic        s2_valid;
    logic [31:0] s2_data;
    logic [5:0]  s2_syn;
    logic        s2_corr;
    logic        s2_uncorr;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

`ifdef DEC_ERR_INJECT_EN
    assign word = din ^ ((inj_en && (inj_pos < 6'd38)) ? (38'd1 << inj_pos) : 38'd0);
`else
    assign word = din;
`endif

    assign chk[0] = ^(word[37:6] & M0);
    assign chk[1] = ^(word[37:6] & M1);
    assign chk[2] = ^(word[37:6] & M2);
    assign chk[3] = ^(word[37:6] & M3);
    assign chk[4] = ^(word[37:6] & M4);
    assign chk[5] = ^(word[37:6] & M5);
    assign syn_in = chk ^ word[5:0];

    // Power-of-2 syndromes never match a data position, so check-bit errors leave data untouched.
    always_comb begin
        flip = '0;
        for (int i = 0; i < 32; i++) begin
            flip[i] = (s1_syn == data_pos(i));
        end
        corr_c   = (s1_syn != 6'd0) && (s1_syn <= 6'd38);
        uncorr_c = (s1_syn > 6'd38);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid   <= 1'b0;
            s1_data    <= '0;
            s1_syn     <= '0;
            s2_valid   <= 1'b0;
            s2_data    <= '0;
            s2_syn     <= '0;
            s2_corr    <= 1'b0;
            s2_uncorr  <= 1'b0;
            out_valid  <= 1'b0;
            dout       <= '0;
            syndrome   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
        end else if (adv) begin
            s1_valid   <= in_valid;
            s1_data    <= word[37:6];
            s1_syn     <= syn_in;
            s2_valid   <= s1_valid;
            s2_data    <= s1_data ^ flip;
            s2_syn     <= s1_syn;
            s2_corr    <= s1_valid && corr_c;
            s2_uncorr  <= s1_valid && uncorr_c;
            out_valid  <= s2_valid;
            dout       <= s2_data;
            syndrome   <= s2_syn;
            err_corr   <= s2_corr;
            err_uncorr <= s2_uncorr;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (cnt_clr) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (out_valid && out_ready) begin
            if (err_corr && (corr_cnt != {CNT_W{1'b1}}))
                corr_cnt <= corr_cnt + 1'b1;
            if (err_uncorr && (uncorr_cnt != {CNT_W{1'b1}}))
                uncorr_cnt <= uncorr_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_38_32_decoder.sv
// tb/tb_hamming_38_32_decoder.sv - table and scoreboard bench for hamming_38_32_decoder.
module tb_hamming_38_32_decoder;

    typedef struct {
        logic [31:0] dout;
        logic [5:0]  syn;
        logic        corr;
        logic        uncorr;
    } exp_t;

    typedef struct {
        logic [37:0] din;
        logic [31:0] dout;
        logic [5:0]  syn;
        logic        corr;
        logic        uncorr;
    } vec_t;

    localparam int NV = 11;

    logic        clk;
    logic        rst_n;
    logic [37:0] din;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dout;
    logic        out_valid;
    logic        out_ready;
    logic [5:0]  syndrome;
    logic        err_corr;
    logic        err_uncorr;
    logic        cnt_clr;
    logic [15:0] corr_cnt;
    logic [15:0] uncorr_cnt;

    logic        in_ready_s;
    logic [31:0] dout_s;
    logic        out_valid_s;
    logic [5:0]  syndrome_s;
    logic        err_corr_s;
    logic        err_uncorr_s;
    logic [1:0]  corr_cnt_s;
    logic [1:0]  uncorr_cnt_s;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   corr_exp = 0;
    int   uncorr_exp = 0;
    exp_t sb[$];
    exp_t cur_exp;
    logic cur_has_exp;
    exp_t mon_e;
    exp_t held;
    logic stalled;
    vec_t tbl[NV];

    hamming_38_32_decoder #(.CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready),
        .dout(dout), .out_valid(out_valid), .out_ready(out_ready), .syndrome(syndrome),
        .err_corr(err_corr), .err_uncorr(err_uncorr), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt), .uncorr_cnt(uncorr_cnt)
`ifdef DEC_ERR_INJECT_EN
        , .inj_en(1'b0), .inj_pos(6'd0)
`endif
    );

    hamming_38_32_decoder #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .in_valid(in_valid), .in_ready(in_ready_s),
        .dout(dout_s), .out_valid(out_valid_s), .out_ready(out_ready), .syndrome(syndrome_s),
        .err_corr(err_corr_s), .err_uncorr(err_uncorr_s), .cnt_clr(cnt_clr),
        .corr_cnt(corr_cnt_s), .uncorr_cnt(uncorr_cnt_s)
`ifdef DEC_ERR_INJECT_EN
        , .inj_en(1'b0), .inj_pos(6'd0)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int satv(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    // Reference decoder: place bits at Hamming positions, syndrome = XOR of set positions.
    function automatic exp_t model(input logic [37:0] w);
        logic [38:0] cw;
        logic [5:0]  s;
        exp_t        e;
        int          n;
        cw = '0;
        n  = 0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) == 0) cw[p] = w[$clog2(p)];
            else begin
                cw[p] = w[6 + n];
                n++;
            end
        end
        s = '0;
        for (int p = 1; p <= 38; p++) if (cw[p]) s = s ^ 6'(p);
        if (s != 0 && s <= 38 && ((int'(s) & (int'(s) - 1)) != 0)) cw[s] = ~cw[s];
        n = 0;
        e.dout = '0;
        for (int p = 1; p <= 38; p++) begin
            if ((p & (p - 1)) != 0) begin
                e.dout[n] = cw[p];
                n++;
            end
        end
        e.syn    = s;
        e.corr   = (s != 0) && (s <= 38);
        e.uncorr = (s > 38);
        return e;
    endfunction

    function automatic logic [37:0] rand_word();
        logic [31:0] m [6];
        logic [31:0] d;
        logic [5:0]  c;
        logic [37:0] w;
        int          k;
        m[0] = 32'h56AAAD5B; m[1] = 32'h9B33366D; m[2] = 32'hE3C3C78E;
        m[3] = 32'h03FC07F0; m[4] = 32'h03FFF800; m[5] = 32'hFC000000;
        d = $urandom;
        for (int j = 0; j < 6; j++) c[j] = ^(d & m[j]);
        w = {d, c};
        k = $urandom_range(0, 39);
        if (k < 38) w[k] = ~w[k];
        return w;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            stalled = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            chk("corr_cnt", corr_cnt, satv(corr_exp, 65535));
            chk("uncorr_cnt", uncorr_cnt, satv(uncorr_exp, 65535));
            chk("corr_cnt_w2", corr_cnt_s, satv(corr_exp, 3));
            chk("uncorr_cnt_w2", uncorr_cnt_s, satv(uncorr_exp, 3));
            if (out_valid && !out_ready) begin
                if (stalled) begin
                    chk("stall_dout", dout, held.dout);
                    chk("stall_syn", syndrome, held.syn);
                    chk("stall_flags", {err_corr, err_uncorr}, {held.corr, held.uncorr});
                end
                held.dout = dout; held.syn = syndrome;
                held.corr = err_corr; held.uncorr = err_uncorr;
                stalled = 1'b1;
            end else begin
                stalled = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 1, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("dout", dout, mon_e.dout);
                    chk("syndrome", syndrome, mon_e.syn);
                    chk("err_corr", err_corr, mon_e.corr);
                    chk("err_uncorr", err_uncorr, mon_e.uncorr);
                    if (mon_e.corr) corr_exp++;
                    if (mon_e.uncorr) uncorr_exp++;
                end
            end
            if (cnt_clr) begin
                corr_exp = 0;
                uncorr_exp = 0;
            end
            if (in_valid && in_ready) sb.push_back(cur_has_exp ? cur_exp : model(din));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [37:0] w, input logic has, input exp_t e);
        logic done;
        din = w;
        in_valid = 1'b1;
        cur_has_exp = has;
        cur_exp = e;
        done = 1'b0;
        for (int g = 0; g < 200 && !done; g++) begin
            @(negedge clk);
            done = in_ready;
            tick();
        end
        if (!done) chk("send_timeout", 0, 1);
        in_valid = 1'b0;
        cur_has_exp = 1'b0;
    endtask

    task automatic drain();
        int g;
        g = 0;
        while ((sb.size() != 0 || out_valid) && g < 200) begin
            tick();
            g++;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic send_m(input logic [37:0] w);
        exp_t e;
        e = model(w);
        send(w, 1'b0, e);
    endtask

    initial begin
        exp_t e;
        logic done;
        rst_n = 1'b0; din = '0; in_valid = 1'b0; out_ready = 1'b1; cnt_clr = 1'b0;
        cur_has_exp = 1'b0; cur_exp = '{default: '0}; stalled = 1'b0;

        tbl[0]  = '{din: {32'h00000000, 6'h00}, dout: 32'h00000000, syn: 6'h00, corr: 1'b0, uncorr: 1'b0};
        tbl[1]  = '{din: {32'hFFFFFFFF, 6'h18}, dout: 32'hFFFFFFFF, syn: 6'h00, corr: 1'b0, uncorr: 1'b0};
        tbl[2]  = '{din: {32'hFFFFFFFE, 6'h18}, dout: 32'hFFFFFFFF, syn: 6'h03, corr: 1'b1, uncorr: 1'b0};
        tbl[3]  = '{din: {32'h7FFFFFFF, 6'h18}, dout: 32'hFFFFFFFF, syn: 6'h26, corr: 1'b1, uncorr: 1'b0};
        tbl[4]  = '{din: {32'hFFFFFFFF, 6'h10}, dout: 32'hFFFFFFFF, syn: 6'h08, corr: 1'b1, uncorr: 1'b0};
        tbl[5]  = '{din: {32'h7FF7FFFF, 6'h18}, dout: 32'h7FF7FFFF, syn: 6'h3F, corr: 1'b0, uncorr: 1'b1};
        tbl[6]  = '{din: {32'hFFFFFFFF, 6'h19}, dout: 32'hFFFFFFFF, syn: 6'h01, corr: 1'b1, uncorr: 1'b0};
        tbl[7]  = '{din: {32'hFDFFFFFF, 6'h18}, dout: 32'hFFFFFFFF, syn: 6'h1F, corr: 1'b1, uncorr: 1'b0};
        tbl[8]  = '{din: {32'hFBFFFFFF, 6'h18}, dout: 32'hFFFFFFFF, syn: 6'h21, corr: 1'b1, uncorr: 1'b0};
        tbl[9]  = '{din: {32'h7FFFFFFF, 6'h19}, dout: 32'h7FFFFFFF, syn: 6'h27, corr: 1'b0, uncorr: 1'b1};
        tbl[10] = '{din: {32'h00000000, 6'h20}, dout: 32'h00000000, syn: 6'h20, corr: 1'b1, uncorr: 1'b0};

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_dout", dout, 0);
        chk("rst_syndrome", syndrome, 0);
        chk("rst_flags", {err_corr, err_uncorr}, 0);
        chk("rst_counters", {corr_cnt, uncorr_cnt}, 0);
        chk("rst_in_ready", in_ready, 1);
        tick();
        rst_n = 1'b1;
        tick();

        din = '0; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("lat_e1_valid", out_valid, 0);
        tick();
        chk("lat_e2_valid", out_valid, 0);
        tick();
        chk("lat_e3_valid", out_valid, 1);
        chk("lat_e3_dout", dout, 0);
        drain();

        for (int i = 0; i < NV; i++) begin
            e.dout = tbl[i].dout; e.syn = tbl[i].syn;
            e.corr = tbl[i].corr; e.uncorr = tbl[i].uncorr;
            send(tbl[i].din, 1'b1, e);
        end
        drain();

        fork
            begin
                for (int i = 0; i < 5; i++) send_m(rand_word());
            end
            begin
                repeat (3) tick();
                out_ready = 1'b0;
                tick();
                chk("stall_out_valid", out_valid, 1);
                chk("stall_in_ready", in_ready, 0);
                repeat (3) tick();
                out_ready = 1'b1;
            end
        join
        drain();

        send_m({32'hFFFFFFFE, 6'h18});
        done = 1'b0;
        for (int g = 0; g < 20 && !done; g++) begin
            if (out_valid) begin
                cnt_clr = 1'b1;
                tick();
                cnt_clr = 1'b0;
                done = 1'b1;
            end else begin
                tick();
            end
        end
        chk("clr_found_output", done, 1);
        @(negedge clk);
        chk("clr_priority_corr", corr_cnt, 0);
        chk("clr_priority_uncorr", uncorr_cnt, 0);
        tick();

        for (int i = 0; i < 4; i++) send_m({32'h7FFFFFFF, 6'h18});
        for (int i = 0; i < 4; i++) send_m({32'h7FF7FFFF, 6'h18});
        drain();
        @(negedge clk);
        chk("sat_corr_w2", corr_cnt_s, 3);
        chk("sat_uncorr_w2", uncorr_cnt_s, 3);
        chk("final_corr_w16", corr_cnt, 4);
        chk("final_uncorr_w16", uncorr_cnt, 4);
        tick();

        for (int i = 0; i < 3; i++) send_m(rand_word());
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_corr_cnt", corr_cnt, 0);
        chk("midrst_uncorr_cnt", uncorr_cnt, 0);
        sb.delete();
        corr_exp = 0;
        uncorr_exp = 0;
        tick();
        rst_n = 1'b1;
        tick();
        send_m({32'hFFFFFFFE, 6'h18});
        drain();
        repeat (4) tick();
        chk("post_rst_no_extra", out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
